// File: rtl/hilo_pkg.sv
// Shared op codes and FSM state encoding for the HI/LO multiply/divide unit.
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/hilo_muldiv_unit_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
// Purely combinational; the caller registers hi_nxt/lo_nxt every cycle.
module muldiv_step #(
   parameter int DATA_W = 32
) (
   input  logic              is_div,
   input  logic [DATA_W-1:0] opnd,
   input  logic [DATA_W-1:0] acc_hi,
   input  logic [DATA_W-1:0] acc_lo,
   output logic [DATA_W-1:0] hi_nxt,
   output logic [DATA_W-1:0] lo_nxt
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
      shifted = {acc_hi, acc_lo[DATA_W-1]};
      diff    = shifted - {1'b0, opnd};
      hi_nxt  = '0;
      lo_nxt  = '0;
      if (!is_div) begin
         hi_nxt = sum[DATA_W:1];
         lo_nxt = {sum[0], acc_lo[DATA_W-1:1]};
      // remainder < divisor keeps diff within DATA_W+1 bits, so the top bit is the borrow
      end else if (!diff[DATA_W]) begin
         hi_nxt = diff[DATA_W-1:0];
         lo_nxt = {acc_lo[DATA_W-2:0], 1'b1};
      end else begin
         hi_nxt = shifted[DATA_W-1:0];
         lo_nxt = {acc_lo[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative mul/div engine; result lands DATA_W+1 edges after accept.
// New ops are accepted only in IDLE (busy low); cancel aborts an in-flight op without touching HI/LO.
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   input  logic [2:0]        op_code,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              cancel,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hilo_hi,
   output logic [DATA_W-1:0] hilo_lo
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W-1:0] acc_hi;
   logic [DATA_W-1:0] acc_lo;
   logic [DATA_W-1:0] orig_a;
   logic              is_div;
   logic              neg_q;
   logic              neg_r;
   logic              div0;

   logic              op_signed;
   logic              op_is_div;
   logic              sgn_a;
   logic              sgn_b;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [DATA_W-1:0] step_hi;
   logic [DATA_W-1:0] step_lo;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0] q_fix;
   logic [DATA_W-1:0] r_fix;

   assign op_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
   assign op_is_div = (op_code == OP_DIV) || (op_code == OP_DIVU);
   assign sgn_a     = op_signed & src_a[DATA_W-1];
   assign sgn_b     = op_signed & src_b[DATA_W-1];
   assign mag_a     = sgn_a ? -src_a : src_a;
   assign mag_b     = sgn_b ? -src_b : src_b;

   assign busy = (state != ST_IDLE);

   muldiv_step #(.DATA_W(DATA_W)) u_step (
      .is_div (is_div),
      .opnd   (opnd),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   // min-int / -1 needs no special case: the magnitude quotient negates back to itself
   assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign q_fix    = neg_q ? -acc_lo : acc_lo;
   assign r_fix    = neg_r ? -acc_hi : acc_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         opnd    <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         orig_a  <= '0;
         is_div  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         div0    <= 1'b0;
         done    <= 1'b0;
         hilo_hi <= '0;
         hilo_lo <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (op_valid && !cancel) begin
                  case (op_code)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        state  <= op_is_div ? ST_DIV : ST_MUL;
                        is_div <= op_is_div;
                        cnt    <= '0;
                        opnd   <= mag_b;
                        acc_hi <= '0;
                        acc_lo <= mag_a;
                        neg_q  <= sgn_a ^ sgn_b;
                        neg_r  <= sgn_a;
                        div0   <= (src_b == '0);
                        orig_a <= src_a;
                     end
                     OP_MTHI: hilo_hi <= src_a;
                     OP_MTLO: hilo_lo <= src_a;
                     default: ;
                  endcase
               end
            end
            ST_MUL, ST_DIV: begin
               if (cancel) begin
                  state <= ST_IDLE;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  cnt    <= cnt + 1'b1;
                  if (cnt == CNT_W'(DATA_W - 1))
                     state <= ST_FIX;
               end
            end
            ST_FIX: begin
               state <= ST_IDLE;
               if (!cancel) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     {hilo_hi, hilo_lo} <= prod_fix;
                  end else if (div0) begin
                     hilo_hi <= orig_a;
                     hilo_lo <= '1;
                  end else begin
                     hilo_hi <= r_fix;
                     hilo_lo <= q_fix;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
